// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and slave FSM states, common to the read and write slaves.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // IDLE: wait for AR | FETCH: read memory for one beat | SEND: hold beat on the data channel
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } axi_state_e;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus a flag for
// bursts the slave cannot legally serve.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [3:0]            i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_err
);

  localparam logic [2:0]            MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_span;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic                  w_wrap_bad;

  assign w_bytes    = ADDR_ONE << i_size;
  assign w_span     = ({{(ADDR_WIDTH-4){1'b0}}, i_len} + ADDR_ONE) << i_size;
  assign w_incr     = i_addr + w_bytes;
  assign w_wrap_bad = !wrap_len_ok(i_len) || ((i_addr & (w_bytes - ADDR_ONE)) != '0);

  always_comb begin
    o_err       = (i_size > MAX_SIZE);
    o_next_addr = i_addr;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_INCR:  o_next_addr = w_incr;
      BURST_WRAP: begin
        o_next_addr = (i_addr & ~(w_span - ADDR_ONE)) | (w_incr & (w_span - ADDR_ONE));
        if (w_wrap_bad) o_err = 1'b1;
      end
      default:     o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read responder: one burst at a time, each beat fetched from a req/ack
// memory port and returned on R with ID, RESP and LAST.
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [3:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic [1:0]            i_arlock,
  input  logic [3:0]            i_arcache,
  input  logic [2:0]            i_arprot,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_mem_rd_req,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  input  logic                  i_mem_rd_ack
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  axi_state_e            r_state, w_state_next;
  logic                  r_arready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [3:0]            r_beat_cnt;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;

  logic                  w_ar_hs, w_fetch_done, w_r_hs, w_mem_req;
  logic [ADDR_WIDTH-1:0] w_gen_addr, w_next_addr;
  logic [2:0]            w_gen_size;
  logic [3:0]            w_gen_len;
  logic [1:0]            w_gen_burst;
  logic                  w_gen_err;
  logic                  w_unused_ar;

  assign w_unused_ar = ^{i_arlock, i_arcache, i_arprot};

  // In IDLE the generator checks the incoming request so the error flag is captured with it
  assign w_gen_addr  = (r_state == ST_IDLE) ? i_araddr  : r_addr;
  assign w_gen_size  = (r_state == ST_IDLE) ? i_arsize  : r_size;
  assign w_gen_len   = (r_state == ST_IDLE) ? i_arlen   : r_len;
  assign w_gen_burst = (r_state == ST_IDLE) ? i_arburst : r_burst;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .i_addr      (w_gen_addr),
    .i_size      (w_gen_size),
    .i_len       (w_gen_len),
    .i_burst     (w_gen_burst),
    .o_next_addr (w_next_addr),
    .o_err       (w_gen_err)
  );

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arready <= (w_state_next == ST_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ar_hs      = 1'b0;
    w_fetch_done = 1'b0;
    w_r_hs       = 1'b0;
    w_mem_req    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_arvalid && r_arready) begin
          w_ar_hs      = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_mem_req = !r_err;
        if (r_err || i_mem_rd_ack) begin
          w_fetch_done = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_rvalid && i_rready) begin
          w_r_hs       = 1'b1;
          w_state_next = r_rlast ? ST_IDLE : ST_FETCH;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_id       <= i_arid;
        r_addr     <= i_araddr;
        r_len      <= i_arlen;
        r_size     <= i_arsize;
        r_burst    <= i_arburst;
        r_err      <= w_gen_err;
        r_beat_cnt <= '0;
      end
      if (w_fetch_done) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_err ? '0 : i_mem_rd_data;
        r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
        r_rlast  <= (r_beat_cnt == r_len);
      end
      if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
        if (!r_rlast) begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
          r_addr     <= w_next_addr;
        end
      end
    end
  end

  assign o_arready     = r_arready;
  assign o_rid         = r_id;
  assign o_rdata       = r_rdata;
  assign o_rresp       = r_rresp;
  assign o_rlast       = r_rlast;
  assign o_rvalid      = r_rvalid;
  assign o_mem_rd_req  = w_mem_req;
  assign o_mem_rd_addr = r_addr & ~((ADDR_ONE << r_size) - ADDR_ONE);

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: vector table of bursts plus reset,
// backpressure and back-to-back sequences against a simple memory responder.
module tb_axi_read_slave;
  import axi_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [1:0]    arlock  = 2'b00;
  logic [3:0]    arcache = 4'h0;
  logic [2:0]    arprot  = 3'b000;
  logic          arvalid;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, stray_data, data_w;
  logic          mem_ack, stray_ack, ack_w;

  assign ack_w  = mem_ack | stray_ack;
  assign data_w = stray_ack ? stray_data : mem_data;

  axi_read_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .i_aclk(clk), .i_areset(areset),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arlock(arlock), .i_arcache(arcache), .i_arprot(arprot),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready),
    .o_mem_rd_req(mem_req), .o_mem_rd_addr(mem_addr),
    .i_mem_rd_data(data_w), .i_mem_rd_ack(ack_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0]   id;
    logic [AW-1:0]   addr;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    int              delay;
    bit              err;
    logic [7:0][31:0] ea;
  } vec_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    int            edge_n;
  } beat_t;

  vec_t          tbl[12];
  int            n_vec = 0;
  beat_t         beats[$];
  logic [AW-1:0] addr_q[$];
  int            req_start_q[$];
  int            ack_q[$];
  int            rv_q[$];
  int            ar_edges[$];
  int            fix_delay = 1;
  bit            rand_delay = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {8'hA5, a[23:0]} ^ 32'h0000_5A00;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // memory responder: ack after fix_delay (or random 0-7) cycles of a request
  initial begin
    int dcnt;
    dcnt     = -1;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (areset) dcnt = -1;
      else if (mem_req) begin
        if (dcnt < 0) begin
          dcnt = rand_delay ? int'($urandom_range(0, 7)) : fix_delay;
          addr_q.push_back(mem_addr);
          req_start_q.push_back(cyc);
        end
        if (dcnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mdata(mem_addr);
          dcnt     = -1;
        end else dcnt--;
      end
    end
  end

  // channel monitor, sampled mid-cycle
  initial begin
    bit prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) prev_rv = 1'b0;
      else begin
        if (rvalid && rready) beats.push_back('{rid, rdata, rresp, rlast, cyc + 1});
        if (mem_req && ack_w) ack_q.push_back(cyc + 1);
        if (rvalid && !prev_rv) rv_q.push_back(cyc);
        if (arvalid && arready) ar_edges.push_back(cyc + 1);
        prev_rv = rvalid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic add_vec(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int delay, input bit err,
                         input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    tbl[n_vec] = '{id, addr, len, size, burst, delay, err, {a7, a6, a5, a4, a3, a2, a1, a0}};
    n_vec++;
  endtask

  // caller is positioned just after a rising edge
  task automatic send_ar(input vec_t v, input bit drop);
    int base, t;
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
    base = ar_edges.size();
    t = 0;
    while (ar_edges.size() == base && t < 64) begin
      @(posedge clk);
      t++;
    end
    chk("ar_accept", 64'(ar_edges.size() > base), 64'd1);
    #1;
    if (drop) arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int t;
    t = 0;
    while (beats.size() < target && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("beat_timeout", 64'(beats.size() >= target), 64'd1);
  endtask

  task automatic check_burst(input vec_t v, input int bb, input int ab, input int kb, input int vb, input int ai);
    int n;
    n = int'(v.len) + 1;
    if (beats.size() < bb + n) return;
    for (int i = 0; i < n; i++) begin
      chk("rid", 64'(beats[bb+i].id), 64'(v.id));
      chk("rresp", 64'(beats[bb+i].resp), v.err ? 64'(RESP_SLVERR) : 64'(RESP_OKAY));
      chk("rlast", 64'(beats[bb+i].last), 64'(i == n - 1));
      chk("rdata", 64'(beats[bb+i].data), v.err ? 64'd0 : 64'(mdata(v.ea[i])));
    end
    if (!v.err) begin
      chk("mem_q_len", 64'((addr_q.size() >= ab + n) && (ack_q.size() >= kb + n) && (rv_q.size() >= vb + n)), 64'd1);
      if ((addr_q.size() >= ab + n) && (ack_q.size() >= kb + n) && (rv_q.size() >= vb + n)) begin
        for (int i = 0; i < n; i++) begin
          chk("mem_addr", 64'(addr_q[ab+i]), 64'(v.ea[i]));
          chk("ack_to_rvalid", 64'(rv_q[vb+i]), 64'(ack_q[kb+i]));
        end
        if (ar_edges.size() > ai) chk("ar_to_req", 64'(req_start_q[ab]), 64'(ar_edges[ai]));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int bb, ab, kb, vb, ai;
    @(posedge clk);
    #1;
    bb = beats.size(); ab = addr_q.size(); kb = ack_q.size(); vb = rv_q.size(); ai = ar_edges.size();
    rand_delay = (v.delay < 0);
    fix_delay  = (v.delay < 0) ? 0 : v.delay;
    send_ar(v, 1'b1);
    wait_beats(bb + int'(v.len) + 1);
    repeat (4) @(posedge clk);
    chk("beat_count", 64'(beats.size() - bb), 64'(int'(v.len) + 1));
    chk("mem_req_count", 64'(addr_q.size() - ab), v.err ? 64'd0 : 64'(int'(v.len) + 1));
    check_burst(v, bb, ab, kb, vb, ai);
  endtask

  initial begin
    vec_t vr, vp, v1, v2;
    int bb, ab, kb, vb, ai, t;

    areset = 1'b1; arvalid = 1'b0; rready = 1'b1; stray_ack = 1'b0; stray_data = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("arready_before_edge", 64'(arready), 64'd0);
    @(posedge clk);
    #1;
    chk("arready_after_release", 64'(arready), 64'd1);

    //       id     addr          len  sz burst        dly err  expected beat addresses
    add_vec(4'd5,  32'h100,      4'd3, 3'd2, BURST_INCR,  1, 0, 32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
    add_vec(4'd2,  32'h18,       4'd3, 3'd2, BURST_WRAP,  1, 0, 32'h18, 32'h1C, 32'h10, 32'h14, 0, 0, 0, 0);
    add_vec(4'd3,  32'h40,       4'd2, 3'd2, BURST_FIXED, 2, 0, 32'h40, 32'h40, 32'h40, 0, 0, 0, 0, 0);
    add_vec(4'd7,  32'h200,      4'd1, 3'd2, 2'b11,       1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(4'd4,  32'h300,      4'd1, 3'd3, BURST_INCR,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(4'd1,  32'h20,       4'd2, 3'd2, BURST_WRAP,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(4'd8,  32'h52,       4'd3, 3'd1, BURST_INCR,  0, 0, 32'h52, 32'h54, 32'h56, 32'h58, 0, 0, 0, 0);
    add_vec(4'd10, 32'h7,        4'd2, 3'd0, BURST_INCR, -1, 0, 32'h7, 32'h8, 32'h9, 0, 0, 0, 0, 0);
    add_vec(4'd11, 32'h1A,       4'd1, 3'd2, BURST_WRAP,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(4'd12, 32'h36,       4'd7, 3'd1, BURST_WRAP, -1, 0, 32'h36, 32'h38, 32'h3A, 32'h3C, 32'h3E, 32'h30, 32'h32, 32'h34);
    add_vec(4'd13, 32'hFFFFFFF8, 4'd3, 3'd2, BURST_INCR,  1, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 0, 0, 0, 0);
    add_vec(4'd14, 32'h103,      4'd1, 3'd2, BURST_INCR,  0, 0, 32'h100, 32'h104, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < n_vec; k++) run_vec(tbl[k]);

    // reset while a beat is waiting on RREADY
    vr = '{4'd6, 32'h500, 4'd3, 3'd2, BURST_INCR, 0, 1'b0, '0};
    @(posedge clk);
    #1;
    bb = beats.size();
    rready = 1'b0; rand_delay = 1'b0; fix_delay = 0;
    send_ar(vr, 1'b1);
    t = 0;
    while (!rvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rvalid_before_reset", 64'(rvalid), 64'd1);
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    chk("midburst_rst_rvalid", 64'(rvalid), 64'd0);
    chk("midburst_rst_req", 64'(mem_req), 64'd0);
    chk("midburst_rst_arready", 64'(arready), 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    chk("midburst_arready_pre", 64'(arready), 64'd0);
    @(posedge clk);
    #1;
    chk("midburst_arready_post", 64'(arready), 64'd1);
    repeat (3) @(posedge clk);
    chk("no_beats_after_reset", 64'(beats.size() - bb), 64'd0);

    // backpressure on beat 2 with a stray ack while the beat is held
    vp = '{4'd9, 32'h400, 4'd3, 3'd2, BURST_INCR, 2, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h40C, 32'h408, 32'h404, 32'h400}};
    @(posedge clk);
    #1;
    bb = beats.size(); ab = addr_q.size(); kb = ack_q.size(); vb = rv_q.size(); ai = ar_edges.size();
    rand_delay = 1'b0; fix_delay = 2;
    send_ar(vp, 1'b1);
    wait_beats(bb + 1);
    #1;
    rready = 1'b0;
    t = 0;
    while (!rvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rvalid", 64'(rvalid), 64'd1);
      chk("bp_rdata", 64'(rdata), 64'(mdata(32'h404)));
      chk("bp_rlast", 64'(rlast), 64'd0);
      chk("bp_no_req", 64'(mem_req), 64'd0);
      chk("bp_arready", 64'(arready), 64'd0);
      @(posedge clk);
      #1;
      stray_data = 32'hDEAD_BEEF;
      stray_ack  = (k == 1);
    end
    stray_ack = 1'b0;
    rready = 1'b1;
    wait_beats(bb + 4);
    repeat (3) @(posedge clk);
    chk("bp_beat_count", 64'(beats.size() - bb), 64'd4);
    chk("bp_req_count", 64'(addr_q.size() - ab), 64'd4);
    check_burst(vp, bb, ab, kb, vb, ai);

    // back-to-back: second AR held valid during the first burst, random ack delay
    v1 = '{4'd1, 32'h80, 4'd1, 3'd2, BURST_INCR, -1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h84, 32'h80}};
    v2 = '{4'd2, 32'h90, 4'd0, 3'd2, BURST_FIXED, -1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h90}};
    @(posedge clk);
    #1;
    bb = beats.size(); ab = addr_q.size(); kb = ack_q.size(); vb = rv_q.size(); ai = ar_edges.size();
    rand_delay = 1'b1;
    send_ar(v1, 1'b0);
    send_ar(v2, 1'b1);
    wait_beats(bb + 3);
    repeat (3) @(posedge clk);
    chk("b2b_beat_count", 64'(beats.size() - bb), 64'd3);
    chk("b2b_req_count", 64'(addr_q.size() - ab), 64'd3);
    if (beats.size() >= bb + 2 && ar_edges.size() >= ai + 2)
      chk("b2b_ar_gap", 64'(ar_edges[ai+1]), 64'(beats[bb+1].edge_n + 1));
    check_burst(v1, bb, ab, kb, vb, ai);
    check_burst(v2, bb + 2, ab + 2, kb + 2, vb + 2, ai + 1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
